// File: rtl/ide_cycle_if.sv
// Bus-side signal bundle for the IDE cycle sequencer.
//   master : 68000 bus / autoconfig side; drives ADDR, strobes, RW and window hits.
//   slave  : ide_cycle_ctrl; drives IDE strobes, DA, ROM enable and DTACK_n.
interface ide_cycle_if;
    logic [23:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        RW;
    logic        ide_access;
    logic        autoconfig_cycle;
    logic        IDE_CS0_n;
    logic        IDE_CS1_n;
    logic        IDE_IOR_n;
    logic        IDE_IOW_n;
    logic [2:0]  IDE_DA;
    logic        ROM_OE_n;
    logic        DTACK_n;

    modport master (
        output ADDR, AS_n, UDS_n, LDS_n, RW, ide_access, autoconfig_cycle,
        input  IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, IDE_DA, ROM_OE_n, DTACK_n
    );

    modport slave (
        input  ADDR, AS_n, UDS_n, LDS_n, RW, ide_access, autoconfig_cycle,
        output IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, IDE_DA, ROM_OE_n, DTACK_n
    );
endinterface

// File: rtl/ide_cycle_ctrl.sv
// Turns qualified 68000 bus cycles into IDE task-file strobes and boot-ROM
// enables, and generates DTACK_n with programmable setup/strobe/hold timing.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : synchronous, active-high
//   bus   : ide_cycle_if.slave (68000 bus inputs in, IDE/ROM/DTACK out)
// DTACK_n is the registered active-low acknowledge; the board top turns it
// into an open-drain driver.
module ide_cycle_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    ide_cycle_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_ACK} state_e;
    typedef enum logic [1:0] {CLS_AC, CLS_ROM, CLS_REG} cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_l_q, rw_l_d;
    logic               cs1_sel_q, cs1_sel_d;
    logic [2:0]         da_q, da_d;
    logic               as_meta_q, as_meta_d, as_s_q, as_s_d;
    logic               ds_meta_q, ds_meta_d, ds_s_q, ds_s_d;
    logic               cs0_n_q, cs0_n_d, cs1_n_q, cs1_n_d;
    logic               ior_n_q, ior_n_d, iow_n_q, iow_n_d;
    logic               rom_oe_n_q, rom_oe_n_d, dtack_n_q, dtack_n_d;
    logic               start_c, reg_c, active_c;
    logic               unused_addr_c;

    assign unused_addr_c = ^{bus.ADDR[23:17], bus.ADDR[15:13], bus.ADDR[11:5], bus.ADDR[1]};

    // Two-flop synchronisers for the asynchronous strobes
    always_comb begin
        as_meta_d = bus.AS_n;
        as_s_d    = as_meta_q;
        ds_meta_d = bus.UDS_n & bus.LDS_n;
        ds_s_d    = ds_meta_q;
    end

    // Cycle sequencer: next state, counter, latched cycle attributes, next outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        rw_l_d    = rw_l_q;
        cls_d     = cls_q;
        cs1_sel_d = cs1_sel_q;
        da_d      = da_q;
        start_c   = !as_s_q && !ds_s_q && (bus.ide_access || bus.autoconfig_cycle);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_c) begin
                    rw_l_d = bus.RW;
                    if (bus.autoconfig_cycle) begin
                        cls_d   = CLS_AC;
                        state_d = ST_ACK;
                    end else if (!bus.ADDR[16]) begin
                        cls_d   = CLS_ROM;
                        state_d = ST_ACK;
                    end else begin
                        cls_d     = CLS_REG;
                        cs1_sel_d = bus.ADDR[12];
                        da_d      = bus.ADDR[4:2];
                        state_d   = ST_SETUP;
                        cnt_d     = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    if (rw_l_q) begin
                        state_d = ST_ACK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD_CYC - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                end
            end
            ST_ACK: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // AS_n release ends the cycle from any busy state; covers ACK exit and abort
        if (state_q != ST_IDLE && as_s_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so they register with it
        active_c   = (state_d != ST_IDLE);
        reg_c      = (cls_d == CLS_REG) && active_c;
        cs0_n_d    = !(reg_c && !cs1_sel_d);
        cs1_n_d    = !(reg_c && cs1_sel_d);
        ior_n_d    = !(reg_c && rw_l_d && (state_d == ST_STROBE || state_d == ST_ACK));
        iow_n_d    = !(reg_c && !rw_l_d && state_d == ST_STROBE);
        rom_oe_n_d = !(cls_d == CLS_ROM && rw_l_d && state_d == ST_ACK);
        dtack_n_d  = !(state_d == ST_ACK);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cls_q      <= CLS_AC;
            rw_l_q     <= 1'b1;
            cs1_sel_q  <= 1'b0;
            da_q       <= '0;
            as_meta_q  <= 1'b1;
            as_s_q     <= 1'b1;
            ds_meta_q  <= 1'b1;
            ds_s_q     <= 1'b1;
            cs0_n_q    <= 1'b1;
            cs1_n_q    <= 1'b1;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            rom_oe_n_q <= 1'b1;
            dtack_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cls_q      <= cls_d;
            rw_l_q     <= rw_l_d;
            cs1_sel_q  <= cs1_sel_d;
            da_q       <= da_d;
            as_meta_q  <= as_meta_d;
            as_s_q     <= as_s_d;
            ds_meta_q  <= ds_meta_d;
            ds_s_q     <= ds_s_d;
            cs0_n_q    <= cs0_n_d;
            cs1_n_q    <= cs1_n_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            rom_oe_n_q <= rom_oe_n_d;
            dtack_n_q  <= dtack_n_d;
        end
    end

    assign bus.IDE_CS0_n = cs0_n_q;
    assign bus.IDE_CS1_n = cs1_n_q;
    assign bus.IDE_IOR_n = ior_n_q;
    assign bus.IDE_IOW_n = iow_n_q;
    assign bus.IDE_DA    = da_q;
    assign bus.ROM_OE_n  = rom_oe_n_q;
    assign bus.DTACK_n   = dtack_n_q;
endmodule

// File: doc/ide_cycle_ctrl.md
# ide_cycle_ctrl

Clocked bus-cycle sequencer downstream of the Zorro II autoconfig decoder. It consumes `ide_access` and `autoconfig_cycle` and turns qualified 68000 bus cycles into IDE task-file strobes (CS0/CS1, IOR/IOW, DA[2:0]) and boot-ROM output enables. It generates the board's DTACK with programmable setup/strobe/hold timing. It has one clock domain; AS_n and the data strobes are synchronised internally.

## Interface
- `SETUP_CYC`, 1: CLK cycles from CS/address valid to strobe assert (1..15).
- `STROBE_CYC`, 4: CLK cycles IOR_n/IOW_n held low before ack or hold (1..15).
- `HOLD_CYC`, 1: write-only CLK cycles with CS held after IOW_n release, before ack (1..15).
- `CLK` input 1: system clock, all logic on rising edge.
- `RESET` input 1: synchronous, active-high.
- `ADDR` input 23 ([23:1]): 68000 address bus.
- `AS_n` input 1: address strobe, asynchronous.
- `UDS_n`, `LDS_n` input 1 each: data strobes, asynchronous.
- `RW` input 1: 1 = read.
- `ide_access` input 1: board 128K window hit, from the autoconfig block.
- `autoconfig_cycle` input 1: autoconfig space hit, from the autoconfig block.
- `IDE_CS0_n`, `IDE_CS1_n` output 1 each: task-file / control-block chip selects.
- `IDE_IOR_n`, `IDE_IOW_n` output 1 each: IDE read/write strobes.
- `IDE_DA` output 3: IDE register address.
- `ROM_OE_n` output 1: boot ROM output enable.
- `DTACK_n` output 1: bus acknowledge; open-drain at top level, driven low only when asserting.

## Operation
- Synchronisers: AS_n and DS_n = UDS_n & LDS_n each pass through 2 flops, giving `as_s` and `ds_s`. Raw RW/ADDR are sampled only while `as_s` is low, so they are stable.
- Cycle start, IDLE only: `as_s`=0 and `ds_s`=0 and (`ide_access` or `autoconfig_cycle`). At start, latch `rw_l`=RW and the class:
  - AC: `autoconfig_cycle`.
  - ROM: `ide_access` & ADDR[16]=0.
  - REG: `ide_access` & ADDR[16]=1.
  - AC has priority over the others.
- REG decode:
  - ADDR[12]=0 selects CS0; ADDR[12]=1 selects CS1.
  - IDE_DA = ADDR[4:2], latched at start.
- States: IDLE, SETUP, STROBE, HOLD, ACK. One 4-bit down-counter `cnt` is loaded on every state entry.
- IDLE:
  - REG start → SETUP, cnt=SETUP_CYC-1.
  - AC or ROM start → ACK.
- SETUP: CS asserted, strobes high. At cnt=0 → STROBE, cnt=STROBE_CYC-1.
- STROBE: CS asserted; IOR_n low if `rw_l`, else IOW_n low. At cnt=0:
  - Read → ACK, with IOR_n kept low.
  - Write → HOLD, cnt=HOLD_CYC-1, with IOW_n released.
- HOLD (write only): CS asserted, IOW_n high. At cnt=0 → ACK.
- ACK:
  - DTACK_n low.
  - REG: CS held. IOR_n is held low for reads so the data stays valid until the CPU latches it.
  - ROM read: ROM_OE_n low in ACK.
  - ROM write: acknowledged, no enable (write ignored).
  - `as_s`=1 → IDLE.
- Abort: in any non-IDLE state, `as_s`=1 → IDLE next edge, all outputs deasserted, no DTACK.
- IDLE outputs: all `_n` outputs high, IDE_DA holds its last value.
- Outputs are registered; none is decoded combinationally from asynchronous inputs.

## Timing
- Reset (next rising edge with RESET=1):
  - State IDLE, cnt=0.
  - `IDE_CS0_n`, `IDE_CS1_n`, `IDE_IOR_n`, `IDE_IOW_n`, `ROM_OE_n`, `DTACK_n` = 1; IDE_DA = 0.
  - Synchroniser flops = 1.
  - Reset mid-cycle overrides everything. No DTACK is produced for that cycle.
- Start latency: 2 CLK from the later of AS_n/DS_n falling (synchroniser), plus 1 edge to leave IDLE.
- REG read, edges after leaving IDLE:
  - CS low for SETUP_CYC cycles before IOR_n falls.
  - IOR_n low STROBE_CYC cycles before DTACK_n falls.
  - DTACK_n stays low until 1 edge after `as_s` rises.
- REG write: IOW_n width = STROBE_CYC; CS held HOLD_CYC after IOW_n rises; DTACK_n falls the edge after HOLD ends.
- AC/ROM: DTACK_n low 1 edge after the start edge.
- Back-to-back cycles: a new start requires IDLE with `as_s` low again. No cycle is acked twice because ACK exits only on `as_s`=1.
- `ide_access` dropping mid-cycle is ignored: the class is latched at start.

## Test plan
- Reset: hold RESET 2 cycles with AS_n low and `ide_access`=1 → all `_n` outputs 1, IDE_DA=0, no DTACK.
- REG read at ADDR=0xE9000C (defaults) → CS0_n low, DA=3, IOR_n low after 1 cycle for 4 cycles, then DTACK_n low. IOR_n and DTACK_n rise 1 edge after `as_s`=1.
- REG write at ADDR=0xE91008, RW=0, HOLD_CYC=2 → CS1_n low, DA=2, IOW_n low for 4 cycles, CS held 2 cycles, then DTACK_n.
- ROM read at 0xE80100 and autoconfig read at 0xE80000 → DTACK_n low 1 edge after start; ROM_OE_n low only for the ROM case. ROM write → DTACK_n with ROM_OE_n high.
- Abort: AS_n rises during STROBE → IOR_n/CS release next edge, state IDLE, DTACK_n never low.
- RESET asserted in ACK → all outputs high next edge. The next cycle runs normally.
